agc_controller: RTL and testbench
=================================

// Module: agc_controller
// PURPOSE
//  Closed-loop automatic gain control sequencer. Consumes the windowed average power from the
//  power estimator, compares it with a target and steps a fixed-point gain word that drives the
//  receive-path scaling multiplier. Runs a fast-acquire / slow-track / hold state machine and blanks
//  the estimates corrupted by its own gain changes.
// PARAMETERS
//  POWER_WIDTH  32            width of average_power (signed, 28 fractional bits)
//  GAIN_WIDTH   16            width of gain (unsigned Q4.12)
//  TARGET       32'h0400_0000 target power (0.25)
//  HYST         32'h0040_0000 in-band half-width: |err| <= HYST means no step
//  LOSS_THRESH  32'h0100_0000 TRACK->ACQUIRE when |err| > LOSS_THRESH
//  STEP_FAST    16'h0100      gain step in ACQUIRE
//  STEP_SLOW    16'h0010      gain step in TRACK
//  GAIN_INIT    16'h1000      gain after reset (1.0)
//  GAIN_MIN     16'h0100      lower clamp
//  GAIN_MAX     16'h7FFF      upper clamp
//  LOCK_COUNT   4             consecutive in-band estimates needed to lock
//  BLANK_EST    1             estimates discarded after each gain change
// PORTS
//  clk            in   1           clock
//  rst            in   1           reset, synchronous, active-high
//  en             in   1           clock enable; low = all state held, inputs ignored
//  new_estimate   in   1           one-cycle strobe, average_power valid
//  average_power  in   POWER_WIDTH signed window-average power
//  freeze         in   1           level; hold gain, enter HOLD
//  gain           out  GAIN_WIDTH  current gain word
//  gain_valid     out  1           one-cycle pulse when gain changes value
//  locked         out  1           high in TRACK (and in HOLD if entered from TRACK)
//  saturated      out  1           last update was clamped
//  state          out  2           0 ACQUIRE, 1 TRACK, 2 HOLD
// BEHAVIOUR
//  - Reset: gain=GAIN_INIT, state=ACQUIRE, locked=0, saturated=0, gain_valid=0, lock/blank counters=0.
//    rst wins over everything, including mid-blank and HOLD.
//  - Estimate accepted when en & new_estimate & ~freeze & blank_cnt==0; if blank_cnt!=0 it is
//    dropped and blank_cnt decrements. Negative average_power treated as 0.
//  - err = power - TARGET, computed POWER_WIDTH+1 bits signed; |err| compared against HYST/LOSS.
//  - Latency: gain/gain_valid/state/locked/saturated update on the edge sampling the accepted estimate
//    (visible next cycle). gain_valid is 0 in every other cycle.
//  - In-band (|err|<=HYST): no gain change; lock_cnt++; ACQUIRE with lock_cnt reaching LOCK_COUNT ->
//    TRACK, locked=1. TRACK stays TRACK. saturated unchanged.
//  - Out-of-band: lock_cnt=0; step=STEP_FAST in ACQUIRE, STEP_SLOW in TRACK; err>0 -> gain-step,
//    err<0 -> gain+step; computed GAIN_WIDTH+1 bits, clamped to [GAIN_MIN,GAIN_MAX];
//    saturated=1 iff clamp applied. gain_valid=1 and blank_cnt=BLANK_EST only if gain value changed.
//  - TRACK with |err|>LOSS_THRESH: state=ACQUIRE, locked=0, step uses STEP_FAST in the same update.
//  - freeze high (en high): next state HOLD, gain held, counters held, estimates dropped; freeze beats a
//    simultaneous new_estimate. On freeze low: return to TRACK if locked else ACQUIRE, lock_cnt=0.
// TESTING
//  1 rst pulse mid-operation -> gain=0x1000, state=0, locked=0, saturated=0, gain_valid=0 next cycle.
//  2 ACQUIRE, est 0x0800_0000 -> gain 0x0F00, gain_valid one cycle; next est dropped (blank);
//    third est 0x0800_0000 -> gain 0x0E00.
//  3 four est 0x0400_0000 -> after 4th state=1, locked=1, gain unchanged, no gain_valid pulse.
//  4 TRACK, est 0x0480_0000 -> gain -0x0010, stay TRACK; later est 0x0600_0000 -> state=0, locked=0,
//    gain -0x0100.
//  5 repeated est 0 from 0x1000 -> +0x100 steps to 0x7F00, next -> 0x7FFF saturated=1 gain_valid=1;
//    next -> 0x7FFF, saturated=1, no gain_valid.
//  6 freeze with simultaneous est 0x0800_0000 -> state=2, gain unchanged; freeze low while locked ->
//    state=1; en low during strobe -> no change.

Source files
------------

// File: rtl/agc_if.sv
// Bundle between the AGC sequencer and the receive path.
// new_estimate is a one-cycle strobe with no back-pressure: average_power is
// valid only in the cycle new_estimate is high (and en is high), and the
// sequencer always consumes or drops it in that same cycle.  gain_valid is
// the matching one-cycle strobe marking a new gain value.
interface agc_if #(
  parameter int POWER_WIDTH = 32,
  parameter int GAIN_WIDTH  = 16
);
  logic                          en;
  logic                          new_estimate;
  logic signed [POWER_WIDTH-1:0] average_power;
  logic                          freeze;
  logic [GAIN_WIDTH-1:0]         gain;
  logic                          gain_valid;
  logic                          locked;
  logic                          saturated;
  logic [1:0]                    state;

  // Receive-path side: supplies estimates/control, observes gain and status.
  modport master (
    output en, new_estimate, average_power, freeze,
    input  gain, gain_valid, locked, saturated, state
  );

  // Sequencer side.
  modport slave (
    input  en, new_estimate, average_power, freeze,
    output gain, gain_valid, locked, saturated, state
  );
endinterface

// File: rtl/agc_controller.sv
// Closed-loop AGC sequencer: compares windowed average power with a target
// and steps a Q4.12 gain word.  States: ACQUIRE (fast steps), TRACK (slow
// steps, locked), HOLD (frozen).  After every gain change the next BLANK_EST
// estimates are discarded because they still reflect the old gain.
module agc_controller #(
  parameter int                    POWER_WIDTH = 32,
  parameter int                    GAIN_WIDTH  = 16,
  parameter logic [POWER_WIDTH-1:0] TARGET      = 32'h0400_0000,
  parameter logic [POWER_WIDTH-1:0] HYST        = 32'h0040_0000,
  parameter logic [POWER_WIDTH-1:0] LOSS_THRESH = 32'h0100_0000,
  parameter logic [GAIN_WIDTH-1:0]  STEP_FAST   = 16'h0100,
  parameter logic [GAIN_WIDTH-1:0]  STEP_SLOW   = 16'h0010,
  parameter logic [GAIN_WIDTH-1:0]  GAIN_INIT   = 16'h1000,
  parameter logic [GAIN_WIDTH-1:0]  GAIN_MIN    = 16'h0100,
  parameter logic [GAIN_WIDTH-1:0]  GAIN_MAX    = 16'h7FFF,
  parameter int                    LOCK_COUNT  = 4,
  parameter int                    BLANK_EST   = 1
) (
  input logic   clk,
  input logic   rst,
  agc_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLD    = 2'd2
  } agc_state_t;

  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int BCW = (BLANK_EST > 0) ? $clog2(BLANK_EST + 1) : 1;
  localparam logic [LCW-1:0] LOCK_MAX   = LCW'(LOCK_COUNT);
  localparam logic [BCW-1:0] BLANK_INIT = BCW'(BLANK_EST);

  // Error arithmetic is one bit wider than the power word so that
  // power - TARGET can never wrap.
  localparam logic signed [POWER_WIDTH:0] TARGET_EXT = {TARGET[POWER_WIDTH-1], TARGET};
  localparam logic [POWER_WIDTH:0]        HYST_EXT   = {1'b0, HYST};
  localparam logic [POWER_WIDTH:0]        LOSS_EXT   = {1'b0, LOSS_THRESH};

  // Gain arithmetic carries two extra bits: one for overflow above
  // GAIN_MAX, one sign bit for underflow below zero.
  localparam logic signed [GAIN_WIDTH+1:0] GAIN_MIN_EXT = {2'b00, GAIN_MIN};
  localparam logic signed [GAIN_WIDTH+1:0] GAIN_MAX_EXT = {2'b00, GAIN_MAX};

  // Registered state and outputs
  agc_state_t            state_q;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic                  gain_valid_q;
  logic                  locked_q;
  logic                  saturated_q;
  logic [LCW-1:0]        lock_cnt_q;
  logic [BCW-1:0]        blank_cnt_q;

  // Combinational datapath
  logic [POWER_WIDTH-1:0]        power_clip;
  logic signed [POWER_WIDTH:0]   err;
  logic [POWER_WIDTH:0]          abs_err;
  logic                          in_band;
  logic                          loss;
  agc_state_t                    base_state;
  logic [LCW-1:0]                base_lock_cnt;
  logic [LCW-1:0]                lock_cnt_inc;
  logic [GAIN_WIDTH-1:0]         step;
  logic signed [GAIN_WIDTH+1:0]  gain_ext;
  logic signed [GAIN_WIDTH+1:0]  step_ext;
  logic signed [GAIN_WIDTH+1:0]  gain_raw;
  logic [GAIN_WIDTH-1:0]         gain_next;
  logic                          clamp_hit;

  // Error magnitude, step selection and clamped candidate gain.
  always_comb begin
    power_clip    = '0;
    err           = '0;
    abs_err       = '0;
    in_band       = 1'b0;
    loss          = 1'b0;
    base_state    = state_q;
    base_lock_cnt = lock_cnt_q;
    lock_cnt_inc  = '0;
    step          = STEP_SLOW;
    gain_ext      = '0;
    step_ext      = '0;
    gain_raw      = '0;
    gain_next     = gain_q;
    clamp_hit     = 1'b0;

    // A negative estimate is physically meaningless; treat it as silence.
    power_clip = bus.average_power[POWER_WIDTH-1] ? '0 : bus.average_power;
    err        = $signed({1'b0, power_clip}) - TARGET_EXT;
    abs_err    = err[POWER_WIDTH] ? $unsigned(-err) : $unsigned(err);
    in_band    = (abs_err <= HYST_EXT);
    loss       = (abs_err >  LOSS_EXT);

    // Leaving HOLD in the same cycle as an estimate: evaluate the estimate
    // against the state being returned to, with a fresh lock count.
    if (state_q == ST_HOLD) begin
      base_state    = locked_q ? ST_TRACK : ST_ACQUIRE;
      base_lock_cnt = '0;
    end

    lock_cnt_inc = (base_lock_cnt == LOCK_MAX) ? base_lock_cnt : base_lock_cnt + 1'b1;

    // Loss of lock in TRACK already uses the fast step in the same update.
    step = ((base_state == ST_ACQUIRE) || loss) ? STEP_FAST : STEP_SLOW;

    gain_ext = $signed({2'b00, gain_q});
    step_ext = $signed({2'b00, step});
    // Power too high (err > 0) -> reduce gain; too low -> increase.
    gain_raw = err[POWER_WIDTH] ? (gain_ext + step_ext) : (gain_ext - step_ext);

    if (gain_raw < GAIN_MIN_EXT) begin
      gain_next = GAIN_MIN;
      clamp_hit = 1'b1;
    end else if (gain_raw > GAIN_MAX_EXT) begin
      gain_next = GAIN_MAX;
      clamp_hit = 1'b1;
    end else begin
      gain_next = gain_raw[GAIN_WIDTH-1:0];
    end
  end

  // Sequencer FSM with registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACQUIRE;
      gain_q       <= GAIN_INIT;
      gain_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      saturated_q  <= 1'b0;
      lock_cnt_q   <= '0;
      blank_cnt_q  <= '0;
    end else begin
      gain_valid_q <= 1'b0;
      if (bus.en) begin
        if (bus.freeze) begin
          // Freeze beats any estimate; gain, counters and locked are held.
          state_q <= ST_HOLD;
        end else begin
          if (state_q == ST_HOLD) begin
            state_q    <= base_state;
            lock_cnt_q <= '0;
          end
          if (bus.new_estimate) begin
            if (blank_cnt_q != '0) begin
              // Estimate still measured at the previous gain: drop it.
              blank_cnt_q <= blank_cnt_q - 1'b1;
            end else if (in_band) begin
              lock_cnt_q <= lock_cnt_inc;
              if ((base_state == ST_ACQUIRE) && (lock_cnt_inc == LOCK_MAX)) begin
                state_q  <= ST_TRACK;
                locked_q <= 1'b1;
              end
            end else begin
              lock_cnt_q  <= '0;
              saturated_q <= clamp_hit;
              if ((base_state == ST_TRACK) && loss) begin
                state_q  <= ST_ACQUIRE;
                locked_q <= 1'b0;
              end
              // A clamp that leaves the gain where it was is not a change:
              // no pulse and no blanking.
              if (gain_next != gain_q) begin
                gain_q       <= gain_next;
                gain_valid_q <= 1'b1;
                blank_cnt_q  <= BLANK_INIT;
              end
            end
          end
        end
      end
    end
  end

  assign bus.gain       = gain_q;
  assign bus.gain_valid = gain_valid_q;
  assign bus.locked     = locked_q;
  assign bus.saturated  = saturated_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_agc_controller.sv
// Directed bench for agc_controller: one vector table walking through
// acquire, blanking, lock, track, loss of lock, freeze and enable gating,
// then hand-written reset and saturation sequences.
module tb_agc_controller;
  localparam int PW = 32;
  localparam int GW = 16;

  localparam logic [31:0] P_HI  = 32'h0800_0000;
  localparam logic [31:0] P_T   = 32'h0400_0000;
  localparam logic [31:0] P_TRK = 32'h0480_0000;
  localparam logic [31:0] P_LOW = 32'h0380_0000;
  localparam logic [31:0] P_LOS = 32'h0600_0000;
  localparam logic [31:0] P_NEG = 32'hF000_0000;
  localparam logic [31:0] P_HB  = 32'h0440_0000;
  localparam logic [31:0] P_HB1 = 32'h0440_0001;

  logic clk = 1'b0;
  logic rst;

  agc_if #(.POWER_WIDTH(PW), .GAIN_WIDTH(GW)) bus ();

  agc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          ne;
    logic          fz;
    logic [31:0]   pwr;
    logic [GW-1:0] gain;
    logic          gv;
    logic [1:0]    st;
    logic          lk;
    logic          sat;
  } vec_t;

  vec_t          vecs[$];
  logic [GW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic vec_t mk(input logic en, ne, fz, input logic [31:0] pwr,
                              input logic [GW-1:0] gain, input logic gv,
                              input logic [1:0] st, input logic lk, sat);
    vec_t v;
    v.en = en; v.ne = ne; v.fz = fz; v.pwr = pwr;
    v.gain = gain; v.gv = gv; v.st = st; v.lk = lk; v.sat = sat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [GW-1:0] gain, input logic gv,
                           input logic [1:0] st, input logic lk, input logic sat);
    check({tag, ".gain"},       32'(bus.gain),       32'(gain));
    check({tag, ".gain_valid"}, 32'(bus.gain_valid), 32'(gv));
    check({tag, ".state"},      32'(bus.state),      32'(st));
    check({tag, ".locked"},     32'(bus.locked),     32'(lk));
    check({tag, ".saturated"},  32'(bus.saturated),  32'(sat));
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1ns after
  // the rising edge that consumed them.
  task automatic drive(input logic en, ne, fz, input logic [31:0] pwr);
    @(negedge clk);
    bus.en            = en;
    bus.new_estimate  = ne;
    bus.freeze        = fz;
    bus.average_power = pwr;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every gain_valid pulse must carry the next expected gain.
  always @(negedge clk) begin
    if (bus.gain_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL gain_pulse: unexpected pulse gain %h", bus.gain);
      end else begin
        check("gain_pulse", 32'(bus.gain), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [GW-1:0] g;

    // Table: each row is one clock; expected outputs visible after it.
    vecs.push_back(mk(1,1,0,P_HI,  16'h0F00,1,0,0,0)); // 0 acquire step down
    vecs.push_back(mk(1,0,0,0,     16'h0F00,0,0,0,0)); // 1 pulse gone
    vecs.push_back(mk(1,1,0,P_HI,  16'h0F00,0,0,0,0)); // 2 blanked
    vecs.push_back(mk(1,1,0,P_HI,  16'h0E00,1,0,0,0)); // 3 second step
    vecs.push_back(mk(1,1,0,P_T,   16'h0E00,0,0,0,0)); // 4 blanked
    vecs.push_back(mk(1,1,0,P_T,   16'h0E00,0,0,0,0)); // 5 in-band 1
    vecs.push_back(mk(1,1,0,P_T,   16'h0E00,0,0,0,0)); // 6 in-band 2
    vecs.push_back(mk(1,1,0,P_T,   16'h0E00,0,0,0,0)); // 7 in-band 3
    vecs.push_back(mk(1,1,0,P_T,   16'h0E00,0,1,1,0)); // 8 in-band 4 -> TRACK
    vecs.push_back(mk(1,1,0,P_TRK, 16'h0DF0,1,1,1,0)); // 9 slow step down
    vecs.push_back(mk(1,1,0,P_T,   16'h0DF0,0,1,1,0)); // 10 blanked
    vecs.push_back(mk(1,1,0,P_T,   16'h0DF0,0,1,1,0)); // 11 in-band in TRACK
    vecs.push_back(mk(1,1,0,P_LOW, 16'h0E00,1,1,1,0)); // 12 slow step up
    vecs.push_back(mk(1,0,0,0,     16'h0E00,0,1,1,0)); // 13 idle
    vecs.push_back(mk(0,1,0,P_HI,  16'h0E00,0,1,1,0)); // 14 en low: ignored
    vecs.push_back(mk(1,1,0,P_LOS, 16'h0E00,0,1,1,0)); // 15 blank still pending
    vecs.push_back(mk(1,1,0,P_LOS, 16'h0D00,1,0,0,0)); // 16 loss -> ACQUIRE fast
    vecs.push_back(mk(1,1,0,P_T,   16'h0D00,0,0,0,0)); // 17 blanked
    vecs.push_back(mk(1,1,0,P_T,   16'h0D00,0,0,0,0)); // 18
    vecs.push_back(mk(1,1,0,P_T,   16'h0D00,0,0,0,0)); // 19
    vecs.push_back(mk(1,1,0,P_T,   16'h0D00,0,0,0,0)); // 20
    vecs.push_back(mk(1,1,0,P_T,   16'h0D00,0,1,1,0)); // 21 relocked
    vecs.push_back(mk(1,1,1,P_HI,  16'h0D00,0,2,1,0)); // 22 freeze beats estimate
    vecs.push_back(mk(1,1,1,P_HI,  16'h0D00,0,2,1,0)); // 23 still HOLD
    vecs.push_back(mk(1,0,0,0,     16'h0D00,0,1,1,0)); // 24 release -> TRACK
    vecs.push_back(mk(0,1,0,P_HI,  16'h0D00,0,1,1,0)); // 25 en low strobe
    vecs.push_back(mk(0,0,1,0,     16'h0D00,0,1,1,0)); // 26 en low freeze
    vecs.push_back(mk(1,1,0,P_TRK, 16'h0CF0,1,1,1,0)); // 27 slow step
    vecs.push_back(mk(1,1,0,P_NEG, 16'h0CF0,0,1,1,0)); // 28 blanked
    vecs.push_back(mk(1,1,0,P_NEG, 16'h0DF0,1,0,0,0)); // 29 negative = 0 -> loss
    vecs.push_back(mk(1,1,0,P_HB,  16'h0DF0,0,0,0,0)); // 30 blanked
    vecs.push_back(mk(1,1,0,P_HB,  16'h0DF0,0,0,0,0)); // 31 |err|==HYST in-band
    vecs.push_back(mk(1,1,0,P_HB1, 16'h0CF0,1,0,0,0)); // 32 HYST+1 steps
    vecs.push_back(mk(1,0,1,0,     16'h0CF0,0,2,0,0)); // 33 freeze unlocked
    vecs.push_back(mk(1,0,0,0,     16'h0CF0,0,0,0,0)); // 34 release -> ACQUIRE

    // Reset
    rst = 1'b1;
    bus.en = 1'b0; bus.new_estimate = 1'b0; bus.freeze = 1'b0; bus.average_power = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("por", 16'h1000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].gv) exp_q.push_back(vecs[i].gain);
      drive(vecs[i].en, vecs[i].ne, vecs[i].fz, vecs[i].pwr);
      check_all($sformatf("row%0d", i), vecs[i].gain, vecs[i].gv, vecs[i].st, vecs[i].lk, vecs[i].sat);
    end

    // Reset mid-operation: in HOLD, blank pending, freeze and strobe high.
    drive(1, 0, 1, 0);
    check_all("hold_pre_rst", 16'h0CF0, 0, 2, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1, P_HI);
    check_all("rst_mid", 16'h1000, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Upward ramp to the clamp; first estimate also proves blank was cleared.
    g = 16'h1000;
    for (int k = 0; k < 'h6F; k++) begin
      g = g + 16'h0100;
      exp_q.push_back(g);
      drive(1, 1, 0, 0);
      check_all($sformatf("ramp%0d", k), g, 1, 0, 0, 0);
      drive(1, 1, 0, 0);
      check_all($sformatf("ramp_blank%0d", k), g, 0, 0, 0, 0);
    end
    exp_q.push_back(16'h7FFF);
    drive(1, 1, 0, 0);
    check_all("clamp_first", 16'h7FFF, 1, 0, 0, 1);
    drive(1, 1, 0, 0);
    check_all("clamp_blank", 16'h7FFF, 0, 0, 0, 1);
    drive(1, 1, 0, 0);
    check_all("clamp_again", 16'h7FFF, 0, 0, 0, 1);
    drive(1, 1, 0, 0);
    check_all("clamp_noblank", 16'h7FFF, 0, 0, 0, 1);
    exp_q.push_back(16'h7EFF);
    drive(1, 1, 0, P_HI);
    check_all("unclamp", 16'h7EFF, 1, 0, 0, 0);

    drive(1, 0, 0, 0);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
